// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and frame layout constants for the SPI controller
//
// Holds the controller state encoding, the 16-bit frame field positions
// {rw, addr[6:0], data[7:0]} and the bit counter width.

package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_e;

    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int BITCNT_W = 5;

endpackage

// File: rtl/spi_ctrl_tx_if.sv
// rtl/spi_ctrl_tx_if.sv - request handshake and SPI pin bundle for spi_ctrl_tx
//
// Signals:
//   req_valid/req_ready  request handshake, fields req_rw/req_addr/req_data
//   done/rx_data/busy    completion pulse, captured cipo word, busy flag
//   sclk/copi/ncs/cipo   SPI mode-0 pins
// Modports:
//   master  the controller (drives SPI pins, answers the handshake)
//   slave   the requester/bench side (drives requests and cipo)

interface spi_ctrl_tx_if;
    import spi_ctrl_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_rw;
    logic [6:0]         req_addr;
    logic [7:0]         req_data;
    logic               done;
    logic [FRAME_W-1:0] rx_data;
    logic               busy;
    logic               sclk;
    logic               copi;
    logic               ncs;
    logic               cipo;

    modport master (
        input  req_valid, req_rw, req_addr, req_data, cipo,
        output req_ready, done, rx_data, busy, sclk, copi, ncs
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_data, cipo,
        input  req_ready, done, rx_data, busy, sclk, copi, ncs
    );

endinterface

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - loadable down-counter timing one SCLK half-period
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      reload the counter with CLK_DIV-1 (takes priority over en)
//   en        count down while nonzero
//   tick      high while the counter is zero (last cycle of the half-period)

module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_ctrl_tx.sv
// rtl/spi_ctrl_tx.sv - SPI mode-0 controller sending one 16-bit register frame per request
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       spi_ctrl_tx_if.master: request handshake, done/rx_data/busy,
//             SPI pins sclk/copi/ncs/cipo
// Frame layout is {rw, addr[6:0], data[7:0]}, MSB first. cipo is captured on
// every sclk rise and the full word is published on rx_data with done.

module spi_ctrl_tx #(
    parameter int CLK_DIV = 4,
    parameter int FRAME_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    spi_ctrl_tx_if.master  bus
);
    import spi_ctrl_pkg::*;

    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_SETUP    = SETUP;
    localparam logic [2:0] ST_SHIFT_HI = SHIFT_HI;
    localparam logic [2:0] ST_SHIFT_LO = SHIFT_LO;
    localparam logic [2:0] ST_HOLD     = HOLD;
    localparam logic [2:0] ST_GAP      = GAP;

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_W - 1);
    localparam logic [BITCNT_W-1:0] ALL_BITS = BITCNT_W'(FRAME_W);

    logic [2:0]          state;
    logic [FRAME_W-1:0]  tx_shift;
    logic [FRAME_W-1:0]  rx_shift;
    logic [FRAME_W-1:0]  rx_q;
    logic [BITCNT_W-1:0] bitcnt;
    logic                ready_q;
    logic                done_q;
    logic                sclk_q;
    logic                copi_q;
    logic                ncs_q;

    logic                accept;
    logic                tick;
    logic                timer_en;
    logic                timer_load;

    assign accept     = bus.req_valid && ready_q;
    assign timer_en   = (state != ST_IDLE);
    // Every non-idle state leaves on a tick, so reloading on accept or on any
    // tick restarts the half-period at each state transition.
    assign timer_load = accept || (timer_en && tick);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_q     <= '0;
            bitcnt   <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            ncs_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_shift[RW_BIT]            <= bus.req_rw;
                        tx_shift[ADDR_MSB:ADDR_LSB] <= bus.req_addr;
                        tx_shift[ADDR_LSB-1:0]      <= bus.req_data;
                        rx_shift <= '0;
                        bitcnt   <= '0;
                        ready_q  <= 1'b0;
                        ncs_q    <= 1'b0;
                        copi_q   <= bus.req_rw;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_SHIFT_LO: begin
                    if (tick) begin
                        sclk_q   <= 1'b1;
                        rx_shift <= {rx_shift[FRAME_W-2:0], bus.cipo};
                        state    <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        sclk_q <= 1'b0;
                        if (bitcnt != ALL_BITS) begin
                            bitcnt <= bitcnt + BITCNT_W'(1);
                        end
                        // The falling edge after the last bit is the start of
                        // HOLD rather than another low phase, which keeps ncs
                        // low for exactly 33 half-periods.
                        if (bitcnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            tx_shift <= tx_shift << 1;
                            copi_q   <= tx_shift[FRAME_W-2];
                            state    <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        ncs_q  <= 1'b1;
                        copi_q <= 1'b0;
                        rx_q   <= rx_shift;
                        done_q <= 1'b1;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.done      = done_q;
    assign bus.rx_data   = rx_q;
    assign bus.sclk      = sclk_q;
    assign bus.copi      = copi_q;
    assign bus.ncs       = ncs_q;

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// tb/tb_spi_ctrl_tx.sv - self-checking bench for spi_ctrl_tx at CLK_DIV 4 and 2

module tb_spi_ctrl_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        valid_drv;
    logic        rw_drv;
    logic [6:0]  addr_drv;
    logic [7:0]  data_drv;
    logic        cipo_drv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_ctrl_tx_if if4 ();
    spi_ctrl_tx_if if2 ();

    spi_ctrl_tx #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    spi_ctrl_tx #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if4.req_valid = valid_drv && !sel;
    assign if2.req_valid = valid_drv && sel;
    assign if4.req_rw    = rw_drv;
    assign if2.req_rw    = rw_drv;
    assign if4.req_addr  = addr_drv;
    assign if2.req_addr  = addr_drv;
    assign if4.req_data  = data_drv;
    assign if2.req_data  = data_drv;
    assign if4.cipo      = cipo_drv;
    assign if2.cipo      = cipo_drv;

    logic        o_ready, o_busy, o_done, o_sclk, o_copi, o_ncs;
    logic [15:0] o_rx;
    assign o_ready = sel ? if2.req_ready : if4.req_ready;
    assign o_busy  = sel ? if2.busy      : if4.busy;
    assign o_done  = sel ? if2.done      : if4.done;
    assign o_sclk  = sel ? if2.sclk      : if4.sclk;
    assign o_copi  = sel ? if2.copi      : if4.copi;
    assign o_ncs   = sel ? if2.ncs       : if4.ncs;
    assign o_rx    = sel ? if2.rx_data   : if4.rx_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the request already on the inputs; returns at
    // the negedge of the first cycle after acceptance.
    task automatic wait_accept(output int waited);
        waited = 0;
        while (!o_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) check("accept_timeout", o_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observes one frame from cycle t0 (index 0) until req_ready returns,
    // driving cipo from pat (changing on sclk falls) and checking the result
    // against timing derived from CLK_DIV and the expected frame word.
    task automatic watch(input int cd, input logic [15:0] exp_frame, input logic [15:0] pat,
                         input int poke_idx, output int high_cnt);
        logic [15:0] bits;
        logic [15:0] rx_at_done;
        logic        prev_sclk, prev_copi;
        int rises, falls, ncs_low, done_cnt, done_idx, ready_idx;
        int first_rise, last_rise, glitches, busy_bad, idx;
        bits = '0; rx_at_done = '0;
        rises = 0; falls = 0; ncs_low = 0; done_cnt = 0; done_idx = -1; ready_idx = -1;
        first_rise = -1; last_rise = -1; glitches = 0; busy_bad = 0; high_cnt = 0;
        prev_sclk = o_sclk; prev_copi = o_copi;
        cipo_drv = pat[15];
        idx = 0;
        while (ready_idx < 0 && idx < 40 * cd) begin
            if (o_busy == o_ready) busy_bad++;
            if (o_ncs) begin
                high_cnt++;
                if (o_sclk) glitches++;
            end else begin
                ncs_low++;
            end
            if (o_sclk && !prev_sclk) begin
                bits = {bits[14:0], o_copi};
                if (rises == 0) first_rise = idx;
                last_rise = idx;
                rises++;
            end
            if (o_sclk && prev_sclk && (o_copi != prev_copi)) glitches++;
            if (!o_sclk && prev_sclk) begin
                falls++;
                if (falls < 16) cipo_drv = pat[15 - falls];
            end
            if (o_done) begin
                done_cnt++;
                done_idx = idx;
                rx_at_done = o_rx;
            end
            if (o_ready && idx > 0) ready_idx = idx;
            if (poke_idx >= 0 && idx == poke_idx) begin
                valid_drv = 1'b1;
                addr_drv  = 7'h03;
            end else if (poke_idx >= 0 && idx == poke_idx + 1) begin
                valid_drv = 1'b0;
            end
            prev_sclk = o_sclk;
            prev_copi = o_copi;
            if (ready_idx < 0) begin
                @(negedge clk);
                idx++;
            end
        end
        check("frame_bits", bits, exp_frame);
        check("rise_count", rises, 16);
        check("first_rise", first_rise, cd);
        check("last_rise", last_rise, 31 * cd);
        check("ncs_low", ncs_low, 33 * cd);
        check("done_count", done_cnt, 1);
        check("done_idx", done_idx, 33 * cd);
        check("rx_data", rx_at_done, pat);
        check("ready_idx", ready_idx, 34 * cd);
        check("pin_glitch", glitches, 0);
        check("busy_inverse", busy_bad, 0);
    endtask

    task automatic send(input int cd, input logic rw, input logic [6:0] addr,
                        input logic [7:0] data, input logic [15:0] pat, input int poke_idx);
        int w, hc;
        rw_drv = rw; addr_drv = addr; data_drv = data;
        valid_drv = 1'b1;
        wait_accept(w);
        valid_drv = 1'b0;
        watch(cd, {rw, addr, data}, pat, poke_idx, hc);
    endtask

    initial begin
        int w, hc, dcnt, lowc, cd;
        logic [15:0] pat;
        rst = 1'b1; sel = 1'b0; valid_drv = 1'b0; rw_drv = 1'b0;
        addr_drv = '0; data_drv = '0; cipo_drv = 1'b0;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_ready", o_ready, 1);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_sclk", o_sclk, 0);
            check("rst_copi", o_copi, 0);
            check("rst_ncs", o_ncs, 1);
            check("rst_rx", o_rx, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // write frame 0x80F0
        send(4, 1'b1, 7'h00, 8'hF0, 16'($urandom), -1);
        // read frame with cipo capture
        send(4, 1'b0, 7'h04, 8'($urandom), 16'hA55A, -1);

        // back-to-back with req_valid held high throughout
        rw_drv = 1'b1; addr_drv = 7'h01; data_drv = 8'h0F; valid_drv = 1'b1;
        wait_accept(w);
        addr_drv = 7'h02; data_drv = 8'hFF;
        watch(4, 16'h810F, 16'($urandom), -1, hc);
        wait_accept(w);
        valid_drv = 1'b0;
        check("b2b_ncs_high", hc + w, 5);
        watch(4, 16'h82FF, 16'($urandom), -1, hc);

        // request pulsed while busy is ignored
        send(4, 1'b1, 7'h05, 8'h3C, 16'($urandom), 40);
        lowc = 0;
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (!o_ncs) lowc++;
            if (!o_ready) dcnt++;
        end
        check("no_extra_frame", lowc, 0);
        check("ready_stays", dcnt, 0);

        // reset in the middle of a frame
        rw_drv = 1'b1; addr_drv = 7'h11; data_drv = 8'h22; valid_drv = 1'b1;
        wait_accept(w);
        valid_drv = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ncs", o_ncs, 1);
        check("mid_rst_sclk", o_sclk, 0);
        check("mid_rst_copi", o_copi, 0);
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_rx", o_rx, 0);
        dcnt = 0;
        lowc = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) dcnt++;
        end
        rst = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (o_done) dcnt++;
            if (!o_ncs) lowc++;
        end
        check("mid_rst_no_done", dcnt, 0);
        check("mid_rst_no_resume", lowc, 0);
        send(4, 1'b1, 7'h2A, 8'h5B, 16'($urandom), -1);

        // minimum divider
        sel = 1'b1;
        @(negedge clk);
        send(2, 1'b1, 7'h7F, 8'h01, 16'($urandom), -1);

        // randomized frames on either divider
        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            @(negedge clk);
            cd = sel ? 2 : 4;
            pat = 16'($urandom);
            send(cd, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), pat, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
